// File: rtl/dehaze_pkg.sv
// Shared definitions for the dehaze datapath.
// Holds the fixed-point widths used between stages and the default tuning
// constants (haze retention, transmission floor, frame size).
package dehaze_pkg;

  localparam int unsigned PIX_W = 8;   // filtered pixel, unsigned integer
  localparam int unsigned INV_W = 16;  // inverse atmospheric light, Q0.16
  localparam int unsigned T_W   = 8;   // transmission, Q0.8

  localparam int unsigned OMEGA_DEF      = 243;     // ~0.95 in Q0.8
  localparam int unsigned T0_DEF         = 26;      // ~0.1 in Q0.8
  localparam int unsigned NUM_PIXELS_DEF = 307200;  // 640x480

endpackage

// File: rtl/transmission_estimator_if.sv
// Pixel stream interface around the transmission estimator.
// Input side : in_valid/in_ready handshake carrying Fc, Inv_Ac, in_last.
// Output side: out_valid/out_ready handshake carrying t_out, out_last.
// master = surrounding logic (upstream source and downstream sink),
// slave  = the estimator.
interface transmission_estimator_if;
  import dehaze_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] Fc;
  logic [INV_W-1:0] Inv_Ac;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [T_W-1:0]   t_out;
  logic             out_last;

  modport master (
    output in_valid, Fc, Inv_Ac, in_last, out_ready,
    input  in_ready, out_valid, t_out, out_last
  );

  modport slave (
    input  in_valid, Fc, Inv_Ac, in_last, out_ready,
    output in_ready, out_valid, t_out, out_last
  );

endinterface

// File: rtl/te_frame_counter.sv
// Per-frame pixel counter for the transmission estimator.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   hs_i           output handshake strobe (out_valid & out_ready)
//   last_i         out_last of the pixel being handed off
//   frame_done_o   one-cycle pulse the cycle after a frame ends
//   length_err_o   sticky: a frame ended on count or on last, but not both
module te_frame_counter
  import dehaze_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic hs_i,
  input  logic last_i,
  output logic frame_done_o,
  output logic length_err_o
);

  localparam int unsigned CNT_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_done_q;
  logic             length_err_q;
  logic             end_cnt, end_last, frame_end;

  assign end_cnt   = hs_i && (cnt_q == CNT_W'(NUM_PIXELS - 1));
  assign end_last  = hs_i && last_i;
  assign frame_end = end_cnt || end_last;

  always_comb begin
    cnt_d = cnt_q;
    if (frame_end)
      cnt_d = '0;
    else if (hs_i)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      length_err_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_done_q <= frame_end;
      // Exactly one of the two end conditions means the frame length was wrong.
      length_err_q <= length_err_q | (end_cnt ^ end_last);
    end
  end

  assign frame_done_o = frame_done_q;
  assign length_err_o = length_err_q;

endmodule

// File: rtl/transmission_estimator.sv
// Transmission estimator: t = max(T0, 1 - OMEGA*min(Fc*Inv_Ac, 1.0)), Q0.8.
// Three-stage pipeline under one global advance; a stalled output freezes
// every stage.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   bus            stream interface (slave side): pixel in, transmission out
//   frame_done_o   one-cycle pulse after the last pixel of a frame is handed off
//   length_err_o   sticky frame length mismatch
module transmission_estimator
  import dehaze_pkg::*;
#(
  parameter int unsigned OMEGA      = OMEGA_DEF,
  parameter int unsigned T0         = T0_DEF,
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  transmission_estimator_if.slave  bus,
  output logic                     frame_done_o,
  output logic                     length_err_o
);

  logic adv;

  // S1: Fc*Inv_Ac is Q8.16; only the Q8.8 part survives the later shift,
  // so the fractional low byte is dropped at the register.
  logic        v1_q, l1_q;
  logic [15:0] p1_q, p1_d;

  // S2: saturated ratio times OMEGA, Q0.16.
  logic        v2_q, l2_q;
  logic [15:0] r_sat;
  logic [16:0] w2_q, w2_d;

  // S3: registered transmission.
  logic        out_valid_q, last_q;
  logic [8:0]  ttmp;
  logic [7:0]  t_q, t_d;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  assign p1_d  = 16'((24'(bus.Fc) * 24'(bus.Inv_Ac)) >> 8);
  assign r_sat = (p1_q > 16'd256) ? 16'd256 : p1_q;
  assign w2_d  = 17'(OMEGA) * 17'(r_sat);
  // W never exceeds 1.0 in Q0.16, so the subtraction cannot wrap.
  assign ttmp  = 9'((17'h10000 - w2_q) >> 8);

  always_comb begin
    if (ttmp > 9'd255)
      t_d = 8'hFF;
    else if (ttmp < 9'(T0))
      t_d = 8'(T0);
    else
      t_d = ttmp[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      l1_q        <= 1'b0;
      p1_q        <= '0;
      v2_q        <= 1'b0;
      l2_q        <= 1'b0;
      w2_q        <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      t_q         <= '0;
    end else if (adv) begin
      v1_q        <= bus.in_valid;
      l1_q        <= bus.in_valid && bus.in_last;
      p1_q        <= p1_d;
      v2_q        <= v1_q;
      l2_q        <= l1_q;
      w2_q        <= w2_d;
      out_valid_q <= v2_q;
      last_q      <= l2_q;
      t_q         <= t_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = last_q;
  assign bus.t_out     = t_q;

  te_frame_counter #(
    .NUM_PIXELS (NUM_PIXELS)
  ) u_frame_counter (
    .clk          (clk),
    .rst          (rst),
    .hs_i         (out_valid_q && bus.out_ready),
    .last_i       (last_q),
    .frame_done_o (frame_done_o),
    .length_err_o (length_err_o)
  );

endmodule

// File: tb/tb_transmission_estimator.sv
module tb_transmission_estimator;
  import dehaze_pkg::*;

  localparam int NPIX = 4;

  logic clk = 1'b0;
  logic rst;
  logic frame_done, length_err;
  int   errors = 0;
  int   checks = 0;

  transmission_estimator_if bus();

  transmission_estimator #(
    .NUM_PIXELS (NPIX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .frame_done_o (frame_done),
    .length_err_o (length_err)
  );

  always #5 clk = ~clk;

  // Reference: real-valued formula evaluated with floor-division integer steps.
  function automatic int ref_t(int fc, int inv);
    int r, tt;
    r = (fc * inv) / 256;
    if (r > 256) r = 256;
    tt = (65536 - int'(OMEGA_DEF) * r) / 256;
    if (tt > 255) return 255;
    if (tt < int'(T0_DEF)) return int'(T0_DEF);
    return tt;
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.Fc        = '0;
    bus.Inv_Ac    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives one pixel and samples out_valid over the next three cycles.
  task automatic send_one(input logic [7:0] fc, input logic [15:0] inv,
                          output logic [7:0] t, output logic early,
                          output logic on_time, output logic acc);
    bus.in_valid  = 1'b1;
    bus.Fc        = fc;
    bus.Inv_Ac    = inv;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk); acc = bus.in_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk); early = bus.out_valid;
    @(negedge clk); early = early | bus.out_valid;
    @(negedge clk); on_time = bus.out_valid; t = bus.t_out;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.t_out !== 8'd0) begin errors++; $display("FAIL rst_t_out: got %0d expected 0", bus.t_out); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b expected 0", bus.out_last); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
    checks++; if (length_err !== 1'b0) begin errors++; $display("FAIL rst_length_err: got %b expected 0", length_err); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b expected 0", bus.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    logic [7:0] t;
    logic early, on_time, acc;
    do_reset();
    send_one(8'd128, 16'd327, t, early, on_time, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL lat_accept: got %b expected 1", acc); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL lat_early: got %b expected 0", early); end
    checks++; if (on_time !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", on_time); end
    checks++; if (t !== 8'd101) begin errors++; $display("FAIL lat_t_out: got %0d expected 101", t); end
  endtask

  task automatic test_saturation();
    logic [7:0]  fcs [8];
    logic [15:0] invs[8];
    logic [7:0]  t;
    logic early, on_time, acc;
    int exp;
    fcs[0] = 8'd255; invs[0] = 16'hFFFF;
    fcs[1] = 8'd0;   invs[1] = 16'($urandom);
    fcs[2] = 8'd0;   invs[2] = 16'hFFFF;
    fcs[3] = 8'd1;   invs[3] = 16'hFFFF;
    for (int i = 4; i < 8; i++) begin
      fcs[i]  = 8'($urandom);
      invs[i] = 16'($urandom_range(0, 2000));
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_one(fcs[i], invs[i], t, early, on_time, acc);
      if (i == 0) exp = 26;
      else if (i < 3) exp = 255;
      else exp = ref_t(int'(fcs[i]), int'(invs[i]));
      checks++; if (on_time !== 1'b1 || t !== 8'(exp)) begin
        errors++; $display("FAIL sat_t_out[%0d]: fc=%0d inv=%0d got valid=%b t=%0d expected %0d", i, fcs[i], invs[i], on_time, t, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  fcs [8];
    logic [15:0] invs[8];
    logic pat[4];
    int   exp_t[$];
    bit   exp_l[$];
    int   sent, got, fd_cnt, e;
    bit   el;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fcs[i]  = 8'($urandom);
      invs[i] = 16'($urandom_range(0, 1500));
    end
    sent = 0; got = 0; fd_cnt = 0;
    do_reset();
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      bus.out_ready = pat[cyc % 4];
      bus.in_valid  = (sent < 8);
      bus.Fc        = fcs[sent % 8];
      bus.Inv_Ac    = invs[sent % 8];
      bus.in_last   = (sent == 3 || sent == 7);
      @(negedge clk);
      if (frame_done === 1'b1) fd_cnt++;
      checks++; if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected %b", cyc, bus.in_ready, !bus.out_valid || bus.out_ready);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t.push_back(ref_t(int'(fcs[sent]), int'(invs[sent])));
        exp_l.push_back(sent == 3 || sent == 7);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        got++;
        checks++;
        if (exp_t.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got t=%0d expected no output", bus.t_out);
        end else begin
          e  = exp_t.pop_front();
          el = exp_l.pop_front();
          if (bus.t_out !== 8'(e) || bus.out_last !== el) begin
            errors++; $display("FAIL b2b_out[%0d]: got t=%0d last=%b expected t=%0d last=%b", got - 1, bus.t_out, bus.out_last, e, el);
          end
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    if (frame_done === 1'b1) fd_cnt++;
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 8", got); end
    checks++; if (exp_t.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d left expected 0", exp_t.size()); end
    checks++; if (fd_cnt != 2) begin errors++; $display("FAIL b2b_frame_done: got %0d pulses expected 2", fd_cnt); end
    checks++; if (length_err !== 1'b0) begin errors++; $display("FAIL b2b_length_err: got %b expected 0", length_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_frame_exact();
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.in_valid = (cyc < 4);
      bus.in_last  = (cyc == 3);
      bus.Fc       = 8'($urandom);
      bus.Inv_Ac   = 16'($urandom);
      @(negedge clk);
      checks++; if (bus.out_valid !== (cyc >= 3 && cyc <= 6)) begin errors++; $display("FAIL fe_out_valid[%0d]: got %b expected %b", cyc, bus.out_valid, cyc >= 3 && cyc <= 6); end
      checks++; if (frame_done !== (cyc == 7)) begin errors++; $display("FAIL fe_frame_done[%0d]: got %b expected %b", cyc, frame_done, cyc == 7); end
      if (cyc == 6) begin
        checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL fe_out_last: got %b expected 1", bus.out_last); end
      end
      @(posedge clk); #1;
    end
    checks++; if (length_err !== 1'b0) begin errors++; $display("FAIL fe_length_err: got %b expected 0", length_err); end
    checks++; if (dut.u_frame_counter.cnt_q !== '0) begin errors++; $display("FAIL fe_count: got %0d expected 0", dut.u_frame_counter.cnt_q); end
  endtask

  task automatic test_frame_short();
    do_reset();
    for (int cyc = 0; cyc < 13; cyc++) begin
      bus.in_valid = (cyc < 7);
      bus.in_last  = (cyc == 2 || cyc == 6);
      bus.Fc       = 8'($urandom);
      bus.Inv_Ac   = 16'($urandom);
      @(negedge clk);
      checks++; if (frame_done !== (cyc == 6 || cyc == 10)) begin errors++; $display("FAIL fs_frame_done[%0d]: got %b expected %b", cyc, frame_done, cyc == 6 || cyc == 10); end
      checks++; if (length_err !== (cyc >= 6)) begin errors++; $display("FAIL fs_length_err[%0d]: got %b expected %b", cyc, length_err, cyc >= 6); end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [7:0]  t;
    logic [7:0]  fc;
    logic [15:0] inv;
    logic early, on_time, acc;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.Fc       = 8'($urandom_range(1, 255));
      bus.Inv_Ac   = 16'($urandom_range(1, 600));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus.out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got %b expected 0", i, bus.out_valid); end
      @(posedge clk); #1;
    end
    fc  = 8'($urandom);
    inv = 16'($urandom_range(0, 1200));
    send_one(fc, inv, t, early, on_time, acc);
    checks++; if (early !== 1'b0 || on_time !== 1'b1) begin errors++; $display("FAIL mid_latency: got early=%b valid=%b expected early=0 valid=1", early, on_time); end
    checks++; if (t !== 8'(ref_t(int'(fc), int'(inv)))) begin errors++; $display("FAIL mid_t_out: got %0d expected %0d", t, ref_t(int'(fc), int'(inv))); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_latency();
    test_saturation();
    test_back_to_back();
    test_frame_exact();
    test_frame_short();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/transmission_estimator.md
Name: transmission_estimator

Overview:
- Consumes the selected minimum filtered pixel Fc and the matching inverse atmospheric light Inv_Ac, both produced by the channel-select multiplexers directly upstream.
- Computes the per-pixel transmission t = max(T0, 1 - OMEGA*min(Fc*Inv_Ac, 1.0)) as an 8-bit Q0.8 value for the scene-recovery stage.
- 3-stage pipeline with valid/ready backpressure, last-pixel sideband, and a per-frame pixel counter with length checking.

Parameters:
- OMEGA, 243, haze-retention factor in Q0.8 (243 ≈ 0.95).
- T0, 26, lower clamp on transmission in Q0.8 (26 ≈ 0.1).
- NUM_PIXELS, 307200, pixels per frame (640x480).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  Fc/Inv_Ac/in_last valid
- in_ready  out  1  block accepts input this cycle
- Fc  in  8  minimum filtered pixel, unsigned integer 0..255
- Inv_Ac  in  16  inverse atmospheric light, Q0.16, floor(65536/A) saturated to 16'hFFFF
- in_last  in  1  final pixel of frame
- out_valid  out  1  t_out valid
- out_ready  in  1  downstream accepts t_out
- t_out  out  8  transmission, Q0.8
- out_last  out  1  in_last delayed with its pixel
- frame_done  out  1  one-cycle pulse after last pixel of frame handed off
- length_err  out  1  sticky, frame length mismatch

Behaviour:
- Reset (asynchronous, rst=1): all stage valids 0, out_valid 0, t_out 0, out_last 0, frame_done 0, length_err 0, pixel count 0.
- Reset mid-frame discards all in-flight pixels; no output handshake occurs for them.
- Global advance: adv = !out_valid | out_ready. in_ready = adv, combinational.
- When adv=0, every stage register, including data and valid, holds.
- Input is accepted on in_valid & in_ready. Bubbles propagate as valid=0.
- Latency: 3 cycles from acceptance to out_valid when there is no stall. Throughput is 1 pixel/cycle.
- S1: P = Fc*Inv_Ac, 24-bit unsigned Q8.16. Register P and last.
- S2: R = P[23:8] in Q8.8, saturated to 16'd256 (1.0). Then W = OMEGA*R, 17-bit unsigned Q0.16, max 65280. Register W and last.
- S3: D = 17'd65536 - W, Q1.16, never negative. Ttmp = D[16:8], 9 bits.
  - If Ttmp > 255, t = 255.
  - Else if Ttmp < T0, t = T0.
  - Else t = Ttmp.
  - Register t_out, out_last, out_valid.
- All arithmetic is unsigned and truncating (floor); the only rounding is the shift.
- Pixel counter increments on each output handshake (out_valid & out_ready).
  - A frame ends when count == NUM_PIXELS-1 or out_last at handshake.
  - Frame end: frame_done pulses high the next cycle for 1 cycle, and count returns to 0.
  - If frame end is caused by only one of those two conditions, length_err sets and stays set until reset.
- Simultaneous stall and frame end: nothing is counted until the handshake completes.

Decomposition:
- Shared package (dehaze_pkg): Q-format widths (PIX_W=8, INV_W=16, T_W=8), OMEGA_DEF, T0_DEF, and NUM_PIXELS_DEF.
- One natural sub-module, te_frame_counter: pixel count, frame_done, length_err. Its inputs are the handshake strobe and out_last.
- The arithmetic pipeline stays inline.

Test Plan:
- Reset then single pixel Fc=128, Inv_Ac=327 (A=200), out_ready=1 -> out_valid exactly 3 cycles after acceptance, t_out=101.
- Fc=255, Inv_Ac=16'hFFFF -> R saturates to 256, raw t=13, so t_out=26 (T0 clamp). Fc=0, any Inv_Ac -> t_out=255 (upper saturation).
- Back-to-back stream of 8 pixels with out_ready toggling 1,0,0,1 -> in_ready mirrors the stall, no pixel is lost or duplicated, and output order and values match the reference model.
- NUM_PIXELS=4 override, 4 pixels with in_last on the 4th -> frame_done pulses once the cycle after the 4th handshake, count returns to 0, length_err=0.
- NUM_PIXELS=4, in_last on the 3rd pixel -> frame_done after the 3rd handshake, length_err=1 and stays set across the following frame.
- Assert rst for 1 cycle with 2 pixels in flight -> out_valid=0 next cycle, no stale output, and the next accepted pixel appears 3 cycles later with the correct value.
